// File: rtl/median9_ctrl.sv
// median9_ctrl: sequential median-of-9 engine for DATA_W-bit pixel streams.
//
// A 3x3 window arrives as nine pixels, row-major (p0 = top-left), on a
// valid/ready stream. One shared three-input sorter is reused for seven cycles:
// three column sorts, three row-stage sorts and one final sort. The median is
// then held on a valid/ready output until it is taken.
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush_in       synchronous abort of the partial window / pending result
//   pix_in         window pixel
//   pix_valid_in   pix_in valid
//   pix_ready_out  block accepts a pixel this cycle (LOAD only)
//   med_out        median of the last complete window
//   med_valid_out  med_out valid
//   med_ready_in   sink accepts med_out
`timescale 1ns/1ps

// Three-input sorter: l >= m >= s. Three magnitude comparators in total.
module three_sort #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] l,
  output logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] s
);
  logic [DATA_W-1:0] ab_hi, ab_lo, lc_hi;

  always_comb begin
    ab_hi = (a >= b) ? a : b;
    ab_lo = (a >= b) ? b : a;
    lc_hi = (ab_lo >= c) ? ab_lo : c;
    s     = (ab_lo >= c) ? c : ab_lo;
    l     = (ab_hi >= lc_hi) ? ab_hi : lc_hi;
    m     = (ab_hi >= lc_hi) ? lc_hi : ab_hi;
  end
endmodule

module median9_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid_in,
  output logic              pix_ready_out,
  output logic [DATA_W-1:0] med_out,
  output logic              med_valid_out,
  input  logic              med_ready_in
);
  typedef enum logic [2:0] {IDLE, LOAD, COL, ROW, FIN, OUT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] win  [0:8];
  logic [DATA_W-1:0] colL [0:2];
  logic [DATA_W-1:0] colM [0:2];
  logic [DATA_W-1:0] colS [0:2];
  logic [DATA_W-1:0] rlo, rmid, rhi, med;
  logic [3:0]        cnt;

  logic [DATA_W-1:0] sa, sb, sc, sl, sm, ss;
  logic [3:0]        col_base;
  logic              accept, out_hs, flush_act;

  assign pix_ready_out = (state == LOAD);
  assign accept        = pix_valid_in && pix_ready_out;
  assign out_hs        = (state == OUT) && med_valid_out && med_ready_in;
  assign flush_act     = flush_in && (state != IDLE);
  assign med_out       = med;
  assign col_base      = {2'b00, cnt[1:0]};

  three_sort #(.DATA_W(DATA_W)) u_sort (
    .a(sa), .b(sb), .c(sc),
    .l(sl), .m(sm), .s(ss)
  );

  // Operand mux: column in COL, one row of column results in ROW,
  // the three row-stage results in FIN.
  always_comb begin
    sa = '0;
    sb = '0;
    sc = '0;
    unique case (state)
      COL: begin
        sa = win[col_base];
        sb = win[col_base + 4'd3];
        sc = win[col_base + 4'd6];
      end
      ROW: begin
        unique case (cnt[1:0])
          2'd0:    begin sa = colS[0]; sb = colS[1]; sc = colS[2]; end
          2'd1:    begin sa = colM[0]; sb = colM[1]; sc = colM[2]; end
          default: begin sa = colL[0]; sb = colL[1]; sc = colL[2]; end
        endcase
      end
      FIN: begin
        sa = rlo;
        sb = rmid;
        sc = rhi;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = LOAD;
      LOAD: if (accept && cnt == 4'd8) state_nxt = COL;
      COL:  if (cnt == 4'd2) state_nxt = ROW;
      ROW:  if (cnt == 4'd2) state_nxt = FIN;
      FIN:  state_nxt = OUT;
      OUT:  if (out_hs) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    // Abort takes priority over any pixel accept or output handshake.
    if (flush_act) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      med_valid_out <= 1'b0;
      med           <= '0;
      rlo           <= '0;
      rmid          <= '0;
      rhi           <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        colL[i] <= '0;
        colM[i] <= '0;
        colS[i] <= '0;
      end
    end else if (flush_act) begin
      cnt           <= '0;
      med_valid_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: cnt <= '0;
        LOAD: if (accept) begin
          win[cnt] <= pix_in;
          cnt      <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
        end
        COL: begin
          colL[cnt[1:0]] <= sl;
          colM[cnt[1:0]] <= sm;
          colS[cnt[1:0]] <= ss;
          cnt            <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
        end
        // Max of column minima, median of medians, min of column maxima.
        ROW: begin
          unique case (cnt[1:0])
            2'd0:    rlo  <= sl;
            2'd1:    rmid <= sm;
            default: rhi  <= ss;
          endcase
          cnt <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
        end
        FIN: begin
          med           <= sm;
          med_valid_out <= 1'b1;
          cnt           <= '0;
        end
        OUT: if (out_hs) begin
          med_valid_out <= 1'b0;
          cnt           <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_median9_ctrl.sv
`timescale 1ns/1ps

module tb_median9_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_in = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid_in = 1'b0;
  logic       pix_ready_out;
  logic [7:0] med_out;
  logic       med_valid_out;
  logic       med_ready_in = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] wv [9];

  median9_ctrl #(.DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_in(flush_in),
    .pix_in(pix_in),
    .pix_valid_in(pix_valid_in),
    .pix_ready_out(pix_ready_out),
    .med_out(med_out),
    .med_valid_out(med_valid_out),
    .med_ready_in(med_ready_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: fifth smallest of the nine window values.
  function automatic logic [7:0] median_ref();
    logic [7:0] a [9];
    logic [7:0] t;
    a = wv;
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0; j--)
        if (a[j-1] > a[j]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    return a[4];
  endfunction

  // Scoreboard consumer: compare on each completed output handshake.
  always @(negedge clk) begin
    if (rst_n && med_valid_out && med_ready_in && !flush_in) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("med", 32'(med_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_pix(input logic [7:0] v);
    int n;
    n = 0;
    pix_in = v;
    pix_valid_in = 1'b1;
    @(negedge clk);
    while (!pix_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("pix_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    pix_valid_in = 1'b0;
  endtask

  task automatic load_win(input bit push);
    for (int i = 0; i < 9; i++) begin
      if (i == 8 && push) exp_q.push_back(median_ref());
      send_pix(wv[i]);
    end
  endtask

  task automatic wait_ready_count(output int n);
    n = 0;
    while (!pix_ready_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!med_valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_timeout", 32'(med_valid_out), 32'd1);
  endtask

  initial begin
    int n;

    // Reset state
    #12;
    chk("rst_pix_ready", 32'(pix_ready_out), 32'd0);
    chk("rst_med_valid", 32'(med_valid_out), 32'd0);
    chk("rst_med_out", 32'(med_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_pix_ready", 32'(pix_ready_out), 32'd0);
    @(posedge clk);
    #1;
    chk("load_pix_ready", 32'(pix_ready_out), 32'd1);

    // 1..9, latency and one-cycle valid
    med_ready_in = 1'b1;
    wv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_win(1'b1);
    chk("p8_ready_fall", 32'(pix_ready_out), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) chk("lat_early", 32'(med_valid_out), 32'd0);
      if (k == 7) begin
        chk("lat_7", 32'(med_valid_out), 32'd1);
        chk("lat_med", 32'(med_out), 32'd5);
        chk("out_ready_low", 32'(pix_ready_out), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    chk("valid_1cyc", 32'(med_valid_out), 32'd0);
    chk("ready_after_hs", 32'(pix_ready_out), 32'd1);

    // 9..1 then 200 x9
    wv = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_win(1'b1);
    wait_ready_count(n);
    chk("gap_a", 32'(n), 32'd8);
    for (int i = 0; i < 9; i++) wv[i] = 8'd200;
    load_win(1'b1);
    wait_ready_count(n);
    chk("gap_b", 32'(n), 32'd8);

    // Duplicates and extremes
    wv = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd7};
    load_win(1'b1);
    wait_ready_count(n);

    // Backpressure: sink stalls 5 cycles
    med_ready_in = 1'b0;
    wv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_win(1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(med_valid_out), 32'd1);
      chk("hold_med", 32'(med_out), 32'd5);
      chk("hold_ready", 32'(pix_ready_out), 32'd0);
      @(posedge clk);
      #1;
    end
    med_ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 32'(med_valid_out), 32'd0);
    chk("bp_ready_back", 32'(pix_ready_out), 32'd1);

    // Flush a partial window
    for (int i = 0; i < 4; i++) send_pix(8'd50);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    chk("flush_ready", 32'(pix_ready_out), 32'd1);
    wv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_win(1'b1);
    wait_ready_count(n);

    // Flush during the output handshake drops that median
    med_ready_in = 1'b0;
    wv = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    load_win(1'b0);
    wait_valid();
    med_ready_in = 1'b1;
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    chk("flush_out_valid", 32'(med_valid_out), 32'd0);
    chk("flush_out_ready", 32'(pix_ready_out), 32'd1);

    // A few random windows
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 9; i++) wv[i] = 8'($urandom_range(0, 255));
      load_win(1'b1);
    end
    wait_ready_count(n);
    wait_ready_count(n);

    // Reset during ROW step 1
    wv = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    load_win(1'b0);
    for (int k = 0; k < 4; k++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pix_ready", 32'(pix_ready_out), 32'd0);
    chk("arst_med_valid", 32'(med_valid_out), 32'd0);
    chk("arst_med_out", 32'(med_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_idle", 32'(pix_ready_out), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_load", 32'(pix_ready_out), 32'd1);
    chk("arst_no_stale", 32'(med_valid_out), 32'd0);
    wv = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    load_win(1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
